// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
//   fetch_state_t        : fetch-stage sequencing states
//   pc_sel_t             : next-PC source select, shared with next-PC logic and decoder
//   RESET_VECTOR_DEFAULT : PC loaded on reset
//   HALT_ADDR_DEFAULT    : PC value at which execution stops
package cpu_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    INCREMENT = 2'd0,
    BRANCH    = 2'd1,
    JUMP      = 2'd2,
    JR        = 2'd3
  } pc_sel_t;

  // Word-align an address by clearing its two low bits.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// PC register and instruction-fetch stage with MIPS branch-delay-slot handling.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   pcnext_in, redirect : next-PC value for the issued instruction; redirect=1 marks a taken target
//   stall               : decode cannot accept the issued instruction this cycle
//   avm_*               : Avalon-MM instruction read master (word reads)
//   pc, instr           : address and word of the issued instruction
//   instr_valid         : pc/instr valid for decode
//   active              : 1 until the halt address is reached
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcnext_in,
  input  logic        redirect,
  input  logic        stall,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        active
);

  fetch_state_t state;
  logic         pending;
  logic [31:0]  target;
  logic [31:0]  new_pc;

  // Next PC on advance: a pending taken target wins over everything (the
  // delay-slot instruction's own redirect is dropped); a fresh redirect
  // first issues the delay slot at pc+4 and parks the target.
  always_comb begin
    new_pc = word_align(pcnext_in);
    if (pending)
      new_pc = target;
    else if (redirect)
      new_pc = pc + 32'd4;
  end

  always_comb begin
    avm_address    = pc;
    avm_read       = !reset && (state == S_FETCH);
    avm_byteenable = avm_read ? 4'b1111 : 4'b0000;
    instr_valid    = !reset && (state == S_ISSUE);
    active         = reset || (state != S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc      <= RESET_VECTOR;
      pending <= 1'b0;
      target  <= '0;
      instr   <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (!avm_waitrequest) begin
            instr <= avm_readdata;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            pc <= new_pc;
            if (pending) begin
              pending <= 1'b0;
            end else if (redirect) begin
              target  <= word_align(pcnext_in);
              pending <= 1'b1;
            end
            state <= (new_pc == HALT_ADDR) ? S_HALT : S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcnext_in;
  logic        redirect;
  logic        stall;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        active;
  logic [31:0] junk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_VECTOR(32'hBFC0_0000),
    .HALT_ADDR   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pcnext_in      (pcnext_in),
    .redirect       (redirect),
    .stall          (stall),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_byteenable (avm_byteenable),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .pc             (pc),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .active         (active)
  );

  // Instruction memory: content is a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  assign avm_readdata = avm_read ? mem_word(avm_address) : junk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: where the machine is in the fetch/issue/halt cycle,
  // the PC it should present, and the queue of redirect targets waiting
  // for their delay slot to retire.
  typedef enum {M_FETCH, M_ISSUE, M_HALT} mphase_t;
  mphase_t     m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_later[$];

  initial begin
    logic [31:0] nxt;
    int unsigned r;
    int unsigned halt_cycles;

    reset = 1'b1; pcnext_in = '0; redirect = 1'b0; stall = 1'b0;
    avm_waitrequest = 1'b0; junk = 32'h1234_5678;
    m_phase = M_FETCH; m_pc = 32'hBFC0_0000; halt_cycles = 0;
    @(posedge clk);

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);

      // Compare outputs against the model for the current cycle.
      if (reset) begin
        check32("rst_read",   {31'b0, avm_read},    32'd0);
        check32("rst_valid",  {31'b0, instr_valid}, 32'd0);
        check32("rst_active", {31'b0, active},      32'd1);
      end else begin
        case (m_phase)
          M_FETCH: begin
            check32("fetch_read",   {31'b0, avm_read},    32'd1);
            check32("fetch_addr",   avm_address,          m_pc);
            check32("fetch_be",     {28'b0, avm_byteenable}, 32'hF);
            check32("fetch_valid",  {31'b0, instr_valid}, 32'd0);
            check32("fetch_active", {31'b0, active},      32'd1);
          end
          M_ISSUE: begin
            check32("issue_read",  {31'b0, avm_read},    32'd0);
            check32("issue_valid", {31'b0, instr_valid}, 32'd1);
            check32("issue_pc",    pc,                   m_pc);
            check32("issue_instr", instr,                mem_word(m_pc));
            check32("issue_active",{31'b0, active},      32'd1);
          end
          default: begin
            check32("halt_active", {31'b0, active},      32'd0);
            check32("halt_read",   {31'b0, avm_read},    32'd0);
            check32("halt_valid",  {31'b0, instr_valid}, 32'd0);
            check32("halt_pc",     pc,                   32'd0);
          end
        endcase
      end

      // Pick inputs for the coming edge.
      halt_cycles = (m_phase == M_HALT && !reset) ? halt_cycles + 1 : 0;
      reset = (halt_cycles > 4) || ($urandom_range(0, 199) == 0);
      avm_waitrequest = ($urandom_range(0, 9) < 4);
      stall           = ($urandom_range(0, 9) < 3);
      redirect        = ($urandom_range(0, 3) == 0);
      junk            = $urandom;
      r = $urandom_range(0, 99);
      if (r < 55)      pcnext_in = m_pc + 32'd4;
      else if (r < 88) pcnext_in = 32'hBFC0_0000 | ($urandom & 32'h0000_03FF);
      else if (r < 93) pcnext_in = 32'h0000_0000 | ($urandom & 32'h3);
      else             pcnext_in = 32'hFFFF_FFFC | ($urandom & 32'h3);

      // Advance the model by the rules for this edge.
      if (reset) begin
        m_phase = M_FETCH;
        m_pc    = 32'hBFC0_0000;
        m_later.delete();
      end else begin
        case (m_phase)
          M_FETCH: if (!avm_waitrequest) m_phase = M_ISSUE;
          M_ISSUE: if (!stall) begin
            if (m_later.size() != 0) begin
              nxt = m_later.pop_front();
            end else if (redirect) begin
              nxt = m_pc + 32'd4;
              m_later.push_back({pcnext_in[31:2], 2'b00});
            end else begin
              nxt = {pcnext_in[31:2], 2'b00};
            end
            m_pc    = nxt;
            m_phase = (nxt == 32'd0) ? M_HALT : M_FETCH;
          end
          default: ;
        endcase
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name:
fetch_unit

Overview:
- PC register and instruction-fetch stage; consumes `pcnext`/`link_pc` from the next-PC logic and feeds the instruction word to the decoder.
- Holds the architectural PC and applies MIPS branch-delay-slot semantics: a taken redirect lands after one more sequential instruction.
- Issues word reads on the Avalon-MM instruction port, tolerating `waitrequest`.
- Halts the CPU when execution reaches address 0.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, PC value that stops fetching.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pcnext_in  in  32  next-PC value from next-PC logic for the currently issued instruction
- redirect  in  1  1 = pcnext_in is a taken branch/jump target (pc_sel != INCREMENT and, for branches, condition true)
- stall  in  1  downstream cannot accept the issued instruction this cycle
- avm_address  out  32  instruction read address (= pc)
- avm_read  out  1  read strobe
- avm_byteenable  out  4  constant 4'b1111 while reading
- avm_waitrequest  in  1  slave not ready; hold request
- avm_readdata  in  32  instruction word
- pc  out  32  address of issued instruction
- instr  out  32  registered instruction word
- instr_valid  out  1  instr/pc valid for decode this cycle
- active  out  1  1 until halt reached

Behaviour:
- States: S_FETCH, S_ISSUE, S_HALT (enum in package).
- Reset (any state, any cycle):
  - Next cycle: state=S_FETCH, pc=RESET_VECTOR, pending=0, target=0, instr=0.
  - instr_valid=0, active=1, avm_read=0 during the reset cycle.
  - An outstanding read is abandoned; its data is never captured.
- S_FETCH:
  - avm_read=1, avm_address=pc, avm_byteenable=4'b1111, instr_valid=0.
  - Address and read are held stable while waitrequest=1.
  - First edge with waitrequest=0: instr<=avm_readdata; go to S_ISSUE.
  - Minimum latency is 1 cycle from read assertion to instr_valid.
  - stall is ignored in this state.
- S_ISSUE:
  - avm_read=0, instr_valid=1; pc/instr held constant.
  - stall=1: remain in S_ISSUE.
  - stall=0 (advance): compute new_pc by priority:
    1. pending=1: new_pc=target; pending<=0. A redirect asserted for the delay-slot instruction is ignored.
    2. redirect=1: new_pc=pc+4 (delay slot); target<=pcnext_in; pending<=1.
    3. else: new_pc=pcnext_in.
  - pc<=new_pc.
  - If new_pc==HALT_ADDR, go to S_HALT; otherwise go to S_FETCH.
- S_HALT:
  - active=0, avm_read=0, instr_valid=0; pc holds HALT_ADDR.
  - Exit only via reset.
- Arithmetic and alignment:
  - pc+4 is 32-bit and wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000), which triggers halt.
  - pc[1:0] is forced to 00 on every load; misaligned pcnext_in/target bits [1:0] are dropped.
- Halt timing:
  - Halt is detected on the PC actually loaded, not on the raw redirect.
  - A jump to 0 halts only after its delay slot has been issued and advanced.
- Throughput: at most one instruction per 2 cycles (fetch, issue). No prefetch.

Decomposition:
- Package cpu_pkg:
  - fetch_state_t enum.
  - RESET_VECTOR_DEFAULT and HALT_ADDR_DEFAULT constants.
  - pc_sel select_t enum (INCREMENT/BRANCH/JUMP/JR), shared with next-PC logic and decoder.
- Single module; no sub-module. The delay-slot pending/target pair stays inline; it is too small for its own block.

Test Plan:
- Reset then memory with waitrequest=0 → avm_read=1 with avm_address=0xBFC00000 one cycle after reset deasserts; next cycle instr_valid=1, instr=readdata.
- waitrequest held high 3 cycles during fetch of 0xBFC00004 → address/read stable for all 4 cycles; instr captured only on the 4th; instr_valid never high early.
- Taken branch at pc=0xBFC00010, redirect=1, pcnext_in=0xBFC00040 → next fetch 0xBFC00014 (delay slot), following fetch 0xBFC00040.
- Redirect during delay slot (jump to 0xBFC00100 asserted while pc=0xBFC00014) → ignored; pc goes to 0xBFC00040.
- JR to 0x00000000 at pc=0xBFC00020 → delay slot 0xBFC00024 issued; after its advance active=0, avm_read=0 permanently, pc=0.
- stall=1 for 5 cycles in S_ISSUE, then reset asserted mid-fetch with waitrequest=1 → pc/instr frozen during stall; after reset pc=0xBFC00000, pending cleared, fresh read issued.
